// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a register file from address 0 to 2**W-1 and
// streams every B-bit register to a UART transmitter, most significant
// byte first, handshaking each byte with o_tx_start / i_tx_done.
module reg_dump_reader #(
    parameter int B = 32,
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [B-1:0] i_reg_data,
    input  logic         i_tx_done,
    output logic [W-1:0] o_reg_addr,
    output logic         o_tx_start,
    output logic [7:0]   o_tx_data,
    output logic         o_busy,
    output logic         o_done
);

    localparam int NB = B / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RD,
        LATCH,
        SEND,
        WAIT_TX,
        DONE
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [B-1:0]  shreg;
    logic [B-1:0]  shreg_d;
    logic [B-1:0]  shifted;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic [W-1:0]  addr_d;
    logic [7:0]    data_d;
    logic          tx_start_d;
    logic          done_d;

    // Next byte always comes from the top of the shift register after a
    // left shift, which keeps the MSB-first slice valid even for B = 8.
    assign shifted = shreg << 8;

    assign o_busy = (state != IDLE);

    // Next-state and next-output computation; all outputs except o_busy
    // are registered, so o_tx_start / o_done appear one cycle after the
    // SEND / DONE state that requests them.
    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        cnt_d      = cnt;
        addr_d     = o_reg_addr;
        data_d     = o_tx_data;
        tx_start_d = 1'b0;
        done_d     = 1'b0;

        case (state)
            IDLE: begin
                if (i_start) begin
                    addr_d  = '0;
                    state_d = WAIT_RD;
                end
            end

            WAIT_RD: begin
                state_d = LATCH;
            end

            LATCH: begin
                shreg_d = i_reg_data;
                cnt_d   = '0;
                data_d  = i_reg_data[B-1 -: 8];
                state_d = SEND;
            end

            SEND: begin
                tx_start_d = 1'b1;
                state_d    = WAIT_TX;
            end

            WAIT_TX: begin
                if (i_tx_done) begin
                    if (cnt != LAST_BYTE) begin
                        shreg_d = shifted;
                        data_d  = shifted[B-1 -: 8];
                        cnt_d   = cnt + 1'b1;
                        state_d = SEND;
                    end else if (o_reg_addr != '1) begin
                        addr_d  = o_reg_addr + 1'b1;
                        state_d = WAIT_RD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset taking priority.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            o_reg_addr <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            state      <= state_d;
            shreg      <= shreg_d;
            cnt        <= cnt_d;
            o_reg_addr <= addr_d;
            o_tx_data  <= data_d;
            o_tx_start <= tx_start_d;
            o_done     <= done_d;
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: a register-file model with one
// cycle read latency, a UART responder that records every byte, and a
// reference byte stream computed directly from the register contents.
module tb_reg_dump_reader;

    localparam int B     = 32;
    localparam int W     = 5;
    localparam int NB    = B / 8;
    localparam int NREG  = 2 ** W;
    localparam int TOTAL = NREG * NB;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_start;
    logic [B-1:0] i_reg_data;
    logic         i_tx_done;
    logic [W-1:0] o_reg_addr;
    logic         o_tx_start;
    logic [7:0]   o_tx_data;
    logic         o_busy;
    logic         o_done;

    logic [B-1:0] mem [NREG];
    logic [7:0]   captured [$];
    logic [7:0]   held;

    int n_asserts  = 0;
    int n_fail     = 0;
    int done_count = 0;
    int pend       = 0;
    int tx_delay   = 2;
    bit rand_delay = 1'b0;
    bit extra_mode = 1'b0;
    bit extra_next = 1'b0;
    bit idle_noise = 1'b0;

    reg_dump_reader #(.B(B), .W(W)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_reg_data (i_reg_data),
        .i_tx_done  (i_tx_done),
        .o_reg_addr (o_reg_addr),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    // register file read port: data for an address appears one edge later
    always @(posedge i_clk) i_reg_data <= mem[o_reg_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int j);
        logic [B-1:0] r;
        r = mem[j / NB];
        return r[(NB - 1 - (j % NB)) * 8 +: 8];
    endfunction

    // UART responder and o_done monitor
    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(negedge i_clk);
            i_tx_done = 1'b0;
            if (o_done) done_count++;
            if (i_reset) begin
                pend       = 0;
                extra_next = 1'b0;
            end else if (pend > 0) begin
                check("tx_data_stable", 32'(o_tx_data), 32'(held));
                pend--;
                if (pend == 0) begin
                    i_tx_done  = 1'b1;
                    extra_next = extra_mode;
                end
            end else if (extra_next) begin
                i_tx_done  = 1'b1;
                extra_next = 1'b0;
            end else if (idle_noise && !o_busy) begin
                i_tx_done = 1'($urandom_range(0, 1));
            end
            if (o_tx_start) begin
                captured.push_back(o_tx_data);
                held = o_tx_data;
                pend = rand_delay ? int'($urandom_range(1, 6)) : tx_delay;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the end within the time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic randomize_mem();
        for (int k = 0; k < NREG; k++) mem[k] = $urandom();
    endtask

    task automatic start_dump();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        int n;
        n = 0;
        while (done_count == base && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        check("done_before_timeout", 32'(done_count != base), 32'd1);
    endtask

    task automatic compare_stream(input string tag, input int base);
        check({tag, "_byte_count"}, 32'(captured.size()), 32'(TOTAL));
        for (int j = 0; j < captured.size() && j < TOTAL; j++)
            check($sformatf("%s_byte%0d", tag, j), 32'(captured[j]), 32'(exp_byte(j)));
        check({tag, "_done_pulses"}, 32'(done_count - base), 32'd1);
        check({tag, "_final_addr"}, 32'(o_reg_addr), 32'(NREG - 1));
        check({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
    endtask

    task automatic finish_dump(input string tag, input int base);
        wait_done(base, 20000);
        repeat (3) @(negedge i_clk);
        compare_stream(tag, base);
    endtask

    task automatic run_dump(input string tag);
        int base;
        captured.delete();
        base = done_count;
        start_dump();
        finish_dump(tag, base);
    endtask

    initial begin
        int base;
        int n;

        i_reset = 1'b1;
        i_start = 1'b0;
        for (int k = 0; k < NREG; k++) mem[k] = 32'h11223344 + 32'(k);

        // reset state
        repeat (3) @(negedge i_clk);
        check("rst_addr", 32'(o_reg_addr), 32'd0);
        check("rst_tx_data", 32'(o_tx_data), 32'd0);
        check("rst_tx_start", 32'(o_tx_start), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);

        // reset and start together: reset wins
        i_start = 1'b1;
        @(negedge i_clk);
        check("rst_start_busy", 32'(o_busy), 32'd0);
        check("rst_start_tx_start", 32'(o_tx_start), 32'd0);
        i_start = 1'b0;
        i_reset = 1'b0;
        repeat (5) @(negedge i_clk);
        check("rst_start_still_idle", 32'(o_busy), 32'd0);
        check("rst_start_no_bytes", 32'(captured.size()), 32'd0);

        // fixed pattern, done two cycles after each start pulse
        tx_delay = 2;
        run_dump("fixed");

        // first-byte latency from a dump started with the address at its top value
        randomize_mem();
        rand_delay = 1'b1;
        captured.delete();
        base = done_count;
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("lat_busy_n", 32'(o_busy), 32'd1);
        check("lat_addr_n", 32'(o_reg_addr), 32'd0);
        check("lat_tx_start_n", 32'(o_tx_start), 32'd0);
        @(negedge i_clk);
        check("lat_tx_start_n1", 32'(o_tx_start), 32'd0);
        @(negedge i_clk);
        check("lat_tx_start_n2", 32'(o_tx_start), 32'd0);
        @(negedge i_clk);
        check("lat_tx_start_n3", 32'(o_tx_start), 32'd1);
        check("lat_tx_data_n3", 32'(o_tx_data), 32'(exp_byte(0)));
        check("lat_addr_n3", 32'(o_reg_addr), 32'd0);
        finish_dump("random", base);

        // slow transmitter plus spurious done ticks outside WAIT_TX
        randomize_mem();
        rand_delay = 1'b0;
        tx_delay   = 50;
        extra_mode = 1'b1;
        idle_noise = 1'b1;
        repeat (10) @(negedge i_clk);
        run_dump("slow_noisy");
        repeat (10) @(negedge i_clk);
        extra_mode = 1'b0;
        idle_noise = 1'b0;
        @(negedge i_clk);

        // start requests hammered during the dump, including in DONE
        randomize_mem();
        rand_delay = 1'b1;
        captured.delete();
        base = done_count;
        start_dump();
        for (n = 0; n < 20000; n++) begin
            @(negedge i_clk);
            if (o_done) break;
            if (captured.size() >= TOTAL) i_start = 1'b1;
            else i_start = 1'($urandom_range(0, 1));
        end
        i_start = 1'b0;
        check("start_noise_done_seen", 32'(n < 20000), 32'd1);
        repeat (3) @(negedge i_clk);
        compare_stream("start_noise", done_count - 1);
        run_dump("redump");

        // reset while register 7 byte 2 waits for its done tick
        randomize_mem();
        rand_delay = 1'b0;
        tx_delay   = 4;
        captured.delete();
        base = done_count;
        start_dump();
        n = 0;
        while (captured.size() < 7 * NB + 3 && n < 5000) begin
            @(negedge i_clk);
            n++;
        end
        check("abort_point_reached", 32'(captured.size()), 32'(7 * NB + 3));
        i_reset = 1'b1;
        @(negedge i_clk);
        check("abort_addr", 32'(o_reg_addr), 32'd0);
        check("abort_tx_data", 32'(o_tx_data), 32'd0);
        check("abort_tx_start", 32'(o_tx_start), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_done", 32'(o_done), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        repeat (30) @(negedge i_clk);
        check("abort_no_more_bytes", 32'(captured.size()), 32'(7 * NB + 3));
        check("abort_no_done", 32'(done_count), 32'(base));
        check("abort_idle", 32'(o_busy), 32'd0);
        rand_delay = 1'b1;
        run_dump("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
